// File: rtl/spi_arbiter.sv
// spi_arbiter - shares the single MCU SPI link (one SPIMux, one nMCUSel)
// between several on-cart SPI masters. Requester 0 is the RTC.
//  - round-robin grant, one owner at a time
//  - owner's SPI controls are muxed combinationally onto the SPIMux inputs
//  - a byte in flight is never cut (DRAIN waits for the owner's clock to stop)
//  - nMCUSel is held high for GUARD_CYCLES cycles between owners
// Optional idle-owner watchdog: compile with SPIARB_TIMEOUT_EN defined.
module spi_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       SClk,
    input  logic                       nReset,
    input  logic [NUM_REQ-1:0]         Req,
    output logic [NUM_REQ-1:0]         Grant,
    input  logic [NUM_REQ-1:0]         ReqClkRunning,
    input  logic [NUM_REQ-1:0]         ReqClkStretch,
    input  logic [NUM_REQ-1:0]         ReqSPIDo,
    input  logic [NUM_REQ-1:0]         ReqnSel,
    output logic                       SPIClkRunning,
    output logic                       SPIClkStretch,
    output logic                       SPIDo,
    output logic                       nMCUSel,
    output logic                       Busy,
    output logic [$clog2(NUM_REQ)-1:0] Owner,
    output logic                       TimeoutFlag
);

    localparam int OWNER_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;

    localparam logic [3:0]         GUARD_LOAD = 4'(GUARD_CYCLES - 1);
    // Pointer starts at the last index so requester 0 wins the first contest.
    localparam logic [OWNER_W-1:0] PTR_INIT   = OWNER_W'(NUM_REQ - 1);

    genvar gi;

    // Reject parameter values the counters and owner encoding cannot hold.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
            TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("spi_arbiter: parameter out of range");
        end
    endgenerate

    logic [1:0]         state_reg, state_next;
    logic [OWNER_W-1:0] owner_reg, owner_next;
    logic [OWNER_W-1:0] ptr_reg, ptr_next;
    logic [3:0]         guard_cnt_reg, guard_cnt_next;
    logic [NUM_REQ-1:0] eligible;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_valid;
    logic               link_owned;
    logic               timeout_fire;
    int                 cand;

`ifdef SPIARB_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]    wd_cnt_reg;
    logic               timeout_flag_reg;
    logic [NUM_REQ-1:0] mask_reg, mask_next;

    // Fires on the cycle the idle-owner count would reach the limit.
    assign timeout_fire = (state_reg == ST_OWNED) && Req[owner_reg] &&
                          !ReqClkRunning[owner_reg] && (wd_cnt_reg == WD_LAST);

    // A timed-out requester stays masked until it drops its Req.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign mask_next[gi] = (timeout_fire && (owner_reg == OWNER_W'(gi))) ? 1'b1
                                 : (mask_reg[gi] & Req[gi]);
            assign eligible[gi]  = Req[gi] & ~mask_reg[gi];
        end
    endgenerate

    // Watchdog: counts owned cycles with the owner's clock stopped, saturating.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            wd_cnt_reg <= '0;
        end else if (state_reg != ST_OWNED || ReqClkRunning[owner_reg]) begin
            wd_cnt_reg <= '0;
        end else if (wd_cnt_reg != WD_MAX) begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end
    end

    // Mask bits and the one-cycle timeout pulse.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            mask_reg         <= '0;
            timeout_flag_reg <= 1'b0;
        end else begin
            mask_reg         <= mask_next;
            timeout_flag_reg <= timeout_fire;
        end
    end

    assign TimeoutFlag = timeout_flag_reg;
`else
    assign timeout_fire = 1'b0;
    assign TimeoutFlag  = 1'b0;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = Req[gi];
        end
    endgenerate
`endif

    // Round-robin pick: first eligible index scanning upward from ptr+1, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = OWNER_W'(cand);
            end
        end
    end

    // Next-state logic for the ownership FSM and guard counter.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        ptr_next       = ptr_reg;
        guard_cnt_next = guard_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_OWNED;
                    owner_next = pick_idx;
                    ptr_next   = pick_idx;
                end
            end
            ST_OWNED: begin
                if (!Req[owner_reg]) begin
                    if (ReqClkRunning[owner_reg]) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next     = ST_GUARD;
                        guard_cnt_next = GUARD_LOAD;
                    end
                end else if (timeout_fire) begin
                    state_next     = ST_GUARD;
                    guard_cnt_next = GUARD_LOAD;
                end
            end
            ST_DRAIN: begin
                // Hold the link until the byte in flight has finished shifting.
                if (!ReqClkRunning[owner_reg]) begin
                    state_next     = ST_GUARD;
                    guard_cnt_next = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    guard_cnt_next = guard_cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM, owner, round-robin pointer and guard counter registers.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            ptr_reg       <= PTR_INIT;
            guard_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
            guard_cnt_reg <= guard_cnt_next;
        end
    end

    assign link_owned = (state_reg == ST_OWNED) || (state_reg == ST_DRAIN);
    assign Busy       = (state_reg != ST_IDLE);
    assign Owner      = owner_reg;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign Grant[gi] = link_owned && (owner_reg == OWNER_W'(gi));
        end
    endgenerate

    // Link mux: follow the owner while owned/draining, otherwise park the link idle.
    always_comb begin
        SPIClkRunning = 1'b0;
        SPIClkStretch = 1'b0;
        SPIDo         = 1'b1;
        nMCUSel       = 1'b1;
        if (link_owned) begin
            SPIClkRunning = ReqClkRunning[owner_reg];
            SPIClkStretch = ReqClkStretch[owner_reg];
            SPIDo         = ReqSPIDo[owner_reg];
            nMCUSel       = ReqnSel[owner_reg];
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter - directed self-checking bench for spi_arbiter
// (NUM_REQ=3, GUARD_CYCLES=4, TIMEOUT_CYCLES=16). The timeout scenario
// depends on whether SPIARB_TIMEOUT_EN is defined.
module tb_spi_arbiter;

    localparam int NUM_REQ        = 3;
    localparam int GUARD_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] req_clk_running;
    logic [2:0] req_clk_stretch;
    logic [2:0] req_spi_do;
    logic [2:0] req_n_sel;
    logic       spi_clk_running;
    logic       spi_clk_stretch;
    logic       spi_do;
    logic       n_mcu_sel;
    logic       busy;
    logic [1:0] owner;
    logic       timeout_flag;

    int checks = 0;
    int errors = 0;

    // Bench SPI device: shifts SPIDo in MSB first on every running-clock cycle while selected.
    logic [7:0] dev_rx;
    int         dev_cnt = 0;
    logic       dev_clr = 1'b0;

    spi_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .GUARD_CYCLES  (GUARD_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .SClk         (clk),
        .nReset       (n_reset),
        .Req          (req),
        .Grant        (grant),
        .ReqClkRunning(req_clk_running),
        .ReqClkStretch(req_clk_stretch),
        .ReqSPIDo     (req_spi_do),
        .ReqnSel      (req_n_sel),
        .SPIClkRunning(spi_clk_running),
        .SPIClkStretch(spi_clk_stretch),
        .SPIDo        (spi_do),
        .nMCUSel      (n_mcu_sel),
        .Busy         (busy),
        .Owner        (owner),
        .TimeoutFlag  (timeout_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dev_clr) begin
            dev_rx  <= 8'h00;
            dev_cnt <= 0;
        end else if (spi_clk_running && !n_mcu_sel) begin
            dev_rx  <= {dev_rx[6:0], spi_do};
            dev_cnt <= dev_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_device();
        dev_clr = 1'b1;
        tick();
        dev_clr = 1'b0;
    endtask

    // Waits (bounded) until the arbiter is back in IDLE; n returns the ticks used.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Clocks one byte out of requester idx, MSB first.
    task automatic send_byte(input int idx, input logic [7:0] data);
        for (int k = 7; k >= 0; k--) begin
            req_clk_running[idx] = 1'b1;
            req_spi_do[idx]      = data[k];
            tick();
        end
        req_clk_running[idx] = 1'b0;
        req_spi_do[idx]      = 1'b1;
    endtask

    task automatic test_reset();
        n_reset         = 1'b0;
        req             = 3'b000;
        req_clk_running = 3'b000;
        req_clk_stretch = 3'b000;
        req_spi_do      = 3'b111;
        req_n_sel       = 3'b111;
        #2;
        checks++;
        if (grant !== 3'b000 || owner !== 2'd0 || busy !== 1'b0 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b owner=%0d busy=%b tflag=%b expected 000/0/0/0",
                     grant, owner, busy, timeout_flag);
        end
        checks++;
        if ({spi_clk_running, spi_clk_stretch, spi_do, n_mcu_sel} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_link: run/str/do/nsel=%b expected 0011",
                     {spi_clk_running, spi_clk_stretch, spi_do, n_mcu_sel});
        end
        tick();
        tick();
        n_reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
        $display("reset: done");
    endtask

    task automatic test_single();
        clear_device();
        req = 3'b001;
        tick();
        checks++;
        if (grant !== 3'b001 || busy !== 1'b1 || owner !== 2'd0) begin
            errors++;
            $display("FAIL single_grant: grant=%b busy=%b owner=%0d expected 001/1/0", grant, busy, owner);
        end
        req_n_sel[0] = 1'b0;
        #1;
        checks++;
        if (n_mcu_sel !== 1'b0) begin
            errors++;
            $display("FAIL single_nsel: nMCUSel=%b expected 0", n_mcu_sel);
        end
        send_byte(0, 8'h13);
        checks++;
        if (dev_rx !== 8'h13 || dev_cnt != 8) begin
            errors++;
            $display("FAIL single_byte: rx=%h bits=%0d expected 13/8", dev_rx, dev_cnt);
        end
        req_n_sel[0] = 1'b1;
        req          = 3'b000;
        tick();
        checks++;
        if (grant !== 3'b000 || busy !== 1'b1 || n_mcu_sel !== 1'b1) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b nsel=%b expected 000/1/1", grant, busy, n_mcu_sel);
        end
        for (int k = 0; k < GUARD_CYCLES - 1; k++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || n_mcu_sel !== 1'b1) begin
                errors++;
                $display("FAIL single_guard%0d: busy=%b nsel=%b expected 1/1", k, busy, n_mcu_sel);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b expected 0", busy);
        end
        $display("single: owner 0 sent byte %h", dev_rx);
    endtask

    task automatic test_contention();
        int         order [4];
        int         prev;
        int         n;
        logic [2:0] exp_grant;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        req = 3'b111;
        tick();
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                prev      = order[g-1];
                req[prev] = 1'b0;
                tick();
                n         = 1;
                req[prev] = 1'b1;
                while (grant === 3'b000 && n < 30) begin
                    tick();
                    n++;
                end
                checks++;
                if (n - 1 != GUARD_CYCLES + 1) begin
                    errors++;
                    $display("FAIL contention_gap%0d: gap=%0d cycles expected %0d", g, n - 1, GUARD_CYCLES + 1);
                end
            end
            exp_grant = 3'b001 << order[g];
            checks++;
            if (grant !== exp_grant || owner !== 2'(order[g])) begin
                errors++;
                $display("FAIL contention_grant%0d: grant=%b owner=%0d expected %b/%0d",
                         g, grant, owner, exp_grant, order[g]);
            end
            $display("contention: grant %0d to owner %0d", g, owner);
            tick();
            tick();
        end
        req = 3'b000;
        wait_idle(n);
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL contention_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic test_drain();
        logic [7:0] data;
        int         n;
        data = 8'hA5;
        clear_device();
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL drain_grant: grant=%b expected 010", grant);
        end
        req_n_sel[1] = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            req_clk_running[1] = 1'b1;
            req_spi_do[1]      = data[k];
            if (k == 3) begin
                req[1] = 1'b0;
            end
            tick();
            if (k <= 3) begin
                checks++;
                if (grant !== 3'b010 || n_mcu_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_hold_bit%0d: grant=%b nsel=%b expected 010/0", k, grant, n_mcu_sel);
                end
            end
        end
        req_clk_running[1] = 1'b0;
        req_spi_do[1]      = 1'b1;
        checks++;
        if (dev_rx !== 8'hA5 || dev_cnt != 8) begin
            errors++;
            $display("FAIL drain_byte: rx=%h bits=%0d expected a5/8", dev_rx, dev_cnt);
        end
        req_n_sel[1] = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b000 || busy !== 1'b1 || n_mcu_sel !== 1'b1) begin
            errors++;
            $display("FAIL drain_release: grant=%b busy=%b nsel=%b expected 000/1/1", grant, busy, n_mcu_sel);
        end
        wait_idle(n);
        checks++;
        if (n != GUARD_CYCLES) begin
            errors++;
            $display("FAIL drain_guard: idle after %0d cycles expected %0d", n, GUARD_CYCLES);
        end
        $display("drain: owner 1 finished byte %h", dev_rx);
    endtask

    task automatic test_reset_mid();
        int n;
        req = 3'b100;
        tick();
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_grant: grant=%b expected 100", grant);
        end
        req_n_sel[2]       = 1'b0;
        req_clk_running[2] = 1'b1;
        req_spi_do[2]      = 1'b0;
        tick();
        tick();
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (spi_clk_running !== 1'b0 || n_mcu_sel !== 1'b1 || grant !== 3'b000 ||
            busy !== 1'b0 || spi_do !== 1'b1 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_async: run=%b nsel=%b grant=%b busy=%b do=%b owner=%0d expected 0/1/000/0/1/0",
                     spi_clk_running, n_mcu_sel, grant, busy, spi_do, owner);
        end
        req_clk_running[2] = 1'b0;
        req_n_sel[2]       = 1'b1;
        req_spi_do[2]      = 1'b1;
        tick();
        n_reset = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b100 || owner !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_regrant: grant=%b owner=%0d expected 100/2", grant, owner);
        end
        req = 3'b000;
        wait_idle(n);
        // Leave requester 0 as last owner, then reset: pointer must return to 2 so 0 wins over 1.
        req = 3'b001;
        tick();
        n_reset = 1'b0;
        #2;
        req     = 3'b011;
        n_reset = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_ptr: grant=%b owner=%0d expected 001/0", grant, owner);
        end
        req = 3'b000;
        wait_idle(n);
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL rstmid_idle: still busy after %0d cycles", n);
        end
        $display("reset_mid: regranted after reset");
    endtask

    task automatic test_noise();
        logic [3:0] vec [4];
        logic [3:0] v;
        int         n;
        vec[0] = 4'b0110; vec[1] = 4'b1000; vec[2] = 4'b0001; vec[3] = 4'b1111;
        req = 3'b001;
        tick();
        req[1]       = 1'b1;
        req_n_sel[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v                  = vec[k];
            req_spi_do[0]      = v[3];
            req_clk_stretch[0] = v[2];
            req_spi_do[1]      = v[1];
            req_n_sel[1]       = v[0];
            req_clk_stretch[1] = ~v[2];
            req_clk_running[1] = 1'b1;
            #1;
            checks++;
            if (spi_do !== v[3] || n_mcu_sel !== 1'b0 || spi_clk_stretch !== v[2] || spi_clk_running !== 1'b0) begin
                errors++;
                $display("FAIL noise_vec%0d: do=%b nsel=%b str=%b run=%b expected %b/0/%b/0",
                         k, spi_do, n_mcu_sel, spi_clk_stretch, spi_clk_running, v[3], v[2]);
            end
            tick();
            checks++;
            if (grant !== 3'b001) begin
                errors++;
                $display("FAIL noise_grant%0d: grant=%b expected 001", k, grant);
            end
        end
        req_clk_running = 3'b000;
        req_clk_stretch = 3'b000;
        req_spi_do      = 3'b111;
        req_n_sel       = 3'b111;
        req[0]          = 1'b0;
        n = 0;
        while (grant !== 3'b010 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (grant !== 3'b010 || n != GUARD_CYCLES + 2) begin
            errors++;
            $display("FAIL noise_handover: grant=%b after %0d cycles expected 010 after %0d",
                     grant, n, GUARD_CYCLES + 2);
        end
        req = 3'b000;
        wait_idle(n);
        $display("noise: requester 0 link unaffected, then owner %0d", owner);
    endtask

    task automatic test_timeout();
        int n;
`ifdef SPIARB_TIMEOUT_EN
        req = 3'b001;
        tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL timeout_grant: grant=%b expected 001", grant);
        end
        req[1] = 1'b1;
        n = 0;
        while (timeout_flag !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != TIMEOUT_CYCLES || grant !== 3'b000) begin
            errors++;
            $display("FAIL timeout_fire: pulse after %0d cycles grant=%b expected %0d/000", n, grant, TIMEOUT_CYCLES);
        end
        tick();
        checks++;
        if (timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: tflag=%b expected 0", timeout_flag);
        end
        n = 0;
        while (grant === 3'b000 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL timeout_next: grant=%b expected 010", grant);
        end
        req[1] = 1'b0;
        wait_idle(n);
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_masked: grant=%b busy=%b expected 000/0", grant, busy);
        end
        req[0] = 1'b0;
        tick();
        req[0] = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL timeout_unmask: grant=%b expected 001", grant);
        end
        req = 3'b000;
        wait_idle(n);
        $display("timeout: watchdog released owner 0");
`else
        logic flag_seen;
        flag_seen = 1'b0;
        req = 3'b001;
        tick();
        for (int k = 0; k < 40; k++) begin
            tick();
            flag_seen = flag_seen | timeout_flag;
        end
        checks++;
        if (grant !== 3'b001 || flag_seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_disabled: grant=%b tflag_seen=%b expected 001/0", grant, flag_seen);
        end
        req = 3'b000;
        wait_idle(n);
        $display("timeout: watchdog absent, owner 0 kept the link");
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_drain();
        test_reset_mid();
        test_noise();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
